// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the frame receiver and the downstream
// scancode decoding stage.
//   FRAME_BITS      : bits per device-to-host frame (start, 8 data, parity, stop)
//   PS2_BREAK/EXT   : scancode prefixes used by the decoder
//   *_IDX           : bit-counter values at which the framing bits arrive
//   odd_parity_ok() : true when data plus parity bit has odd weight
package ps2_pkg;

  localparam int FRAME_BITS = 11;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef logic [3:0] bitcnt_t;

  localparam bitcnt_t START_IDX  = 4'd0;
  localparam bitcnt_t PARITY_IDX = 4'd9;
  localparam bitcnt_t STOP_IDX   = bitcnt_t'(FRAME_BITS - 1);

  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Synchronous show-ahead byte FIFO. The head entry is always on dout;
// pop advances it. A push into a full FIFO is accepted only when a pop
// frees the head slot in the same cycle; otherwise it is ignored.
//   clk, resetn : clock, asynchronous active-low reset
//   push, din   : write request and byte
//   pop         : read request (ignored while empty)
//   dout        : head byte
//   level       : occupancy 0..DEPTH
//   full, empty : occupancy status
module ps2_byte_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  // When full, a simultaneous pop vacates the slot wr_ptr points at.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: the storage array is cleared on reset because the head byte is
  // visible on dout at all times and must read 8'h00 after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      level <= level + LW'(1);
      else if (do_pop && !do_push) level <= level - LW'(1);
    end
  end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver. Synchronises the raw PS/2 pins,
// deserialises 11-bit frames on ps2_clk falling edges, checks start,
// odd parity and stop, and queues good bytes for the downstream stage.
//   clk, resetn        : system clock, asynchronous active-low reset
//   ps2_clk, ps2_data  : raw asynchronous PS/2 pins
//   rd_ready           : consumer takes the head byte this cycle
//   clr_err            : clears the sticky flags (a same-cycle error wins)
//   data, valid, level : FIFO head byte, non-empty, occupancy
//   bitcnt             : bits received in the current frame
//   overflow           : a good byte was dropped on a full FIFO
//   frame_err          : bad start/parity/stop, or inter-bit timeout
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 10000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_ready,
  input  logic       clr_err,
  output logic [7:0] data,
  output logic       valid,
  output logic [4:0] level,
  output logic [3:0] bitcnt,
  output logic       overflow,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]    clk_sync;
  // Data is sampled from stage 1, so a later stage would have no reader.
  logic [1:0]    data_sync;
  logic          fall;
  logic          bit_in;
  logic [7:0]    shreg;
  logic          parity_bit;
  logic [TW-1:0] to_cnt;

  logic          stop_edge;
  logic          push;
  logic          pop;
  logic          start_err;
  logic          timeout;
  logic          frame_bad;
  logic          drop;

  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;

  // NOTE: every register here uses <= so all flops sample the values from
  // before the clock edge; blocking = would collapse the synchroniser chain.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync  <= 3'b111;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign fall   = clk_sync[2] & ~clk_sync[1];
  assign bit_in = data_sync[1];

  // NOTE: each signal is assigned on every path through this block, so no
  // latch can be inferred.
  always_comb begin
    stop_edge = fall && (bitcnt == STOP_IDX);
    push      = stop_edge && bit_in && odd_parity_ok(shreg, parity_bit);
    start_err = fall && (bitcnt == START_IDX) && bit_in;
    timeout   = !fall && (bitcnt != START_IDX) && (to_cnt == TW'(TIMEOUT_CYC - 1));
    frame_bad = start_err || (stop_edge && !push) || timeout;
    pop       = !fifo_empty && rd_ready;
    drop      = push && fifo_full && !pop;
  end

  // Frame shifter: data arrives LSB first, so shifting right leaves the
  // first data bit in shreg[0] after eight data edges.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bitcnt     <= START_IDX;
      shreg      <= '0;
      parity_bit <= 1'b0;
      to_cnt     <= '0;
    end else if (fall) begin
      to_cnt <= '0;
      case (bitcnt)
        START_IDX:  if (!bit_in) bitcnt <= bitcnt + 4'd1;
        PARITY_IDX: begin
          parity_bit <= bit_in;
          bitcnt     <= STOP_IDX;
        end
        STOP_IDX:   bitcnt <= START_IDX;
        default: begin
          shreg  <= {bit_in, shreg[7:1]};
          bitcnt <= bitcnt + 4'd1;
        end
      endcase
    end else if (timeout) begin
      bitcnt <= START_IDX;
      to_cnt <= '0;
    end else if (bitcnt != START_IDX) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  // Sticky flags: a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= (frame_err && !clr_err) || frame_bad;
      overflow  <= (overflow && !clr_err) || drop;
    end
  end

  ps2_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .din    (shreg),
    .dout   (data),
    .level  (fifo_level),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign valid = !fifo_empty;
  assign level = 5'(fifo_level);

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Bench for ps2_frame_rx: directed PS/2 frames; expected bytes go into a
// queue and a negedge monitor compares every FIFO pop against it.
module tb_ps2_frame_rx;

  localparam int DEPTH = 8;
  localparam int TO    = 200;

  logic       clk      = 1'b0;
  logic       resetn   = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_ready = 1'b0;
  logic       clr_err  = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic [4:0] level;
  logic [3:0] bitcnt;
  logic       overflow;
  logic       frame_err;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  logic [8:0] par_tab;

  ps2_frame_rx #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rd_ready  (rd_ready),
    .clr_err   (clr_err),
    .data      (data),
    .valid     (valid),
    .level     (level),
    .bitcnt    (bitcnt),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a pop happens at the next posedge whenever valid
  // and rd_ready are both high at this negedge.
  always @(negedge clk) begin
    if (resetn && valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got %0h want none", data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pop_data", data, mon_exp);
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame bits LSB first: {stop, parity, data[7:0], start}.
  task automatic send_bits(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      tick(4);
      ps2_clk = 1'b0;
      tick(8);
      ps2_clk = 1'b1;
      tick(4);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic p);
    send_bits({1'b1, p, d, 1'b0}, 11);
  endtask

  task automatic drain();
    rd_ready = 1'b1;
    for (int i = 0; i < 40 && valid; i++) tick(1);
    rd_ready = 1'b0;
    check("drain_empty", valid, 0);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
  endtask

  initial begin
    par_tab = 9'b100110100;  // odd-parity bits for bytes 0x01..0x09

    // Reset state
    tick(3);
    check("rst_valid", valid, 0);
    check("rst_level", level, 0);
    check("rst_bitcnt", bitcnt, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_data", data, 8'h00);
    resetn = 1'b1;
    tick(3);

    // 1: single byte, push latency
    exp_q.push_back(8'h1C);
    fork
      send_byte(8'h1C, 1'b0);
      begin : t1_watch
        int   n;
        logic prev_valid;
        n = 0;
        while (bitcnt != 4'd10 && n < 2000) begin @(negedge clk); n++; end
        check("t1_reach_stop", bitcnt, 10);
        prev_valid = valid;
        n = 0;
        while (bitcnt == 4'd10 && n < 100) begin prev_valid = valid; @(negedge clk); n++; end
        check("t1_valid_before", prev_valid, 0);
        check("t1_valid_after", valid, 1);
        check("t1_level_after", level, 1);
        check("t1_bitcnt_after", bitcnt, 0);
        check("t1_data", data, 8'h1C);
      end
    join
    check("t1_frame_err", frame_err, 0);
    drain();

    // 2: two bytes, pop sequence
    exp_q.push_back(8'hF0);
    send_byte(8'hF0, 1'b1);
    exp_q.push_back(8'h1C);
    send_byte(8'h1C, 1'b0);
    check("t2_level2", level, 2);
    check("t2_head", data, 8'hF0);
    rd_ready = 1'b1;
    tick(1);
    check("t2_level1", level, 1);
    tick(1);
    rd_ready = 1'b0;
    check("t2_level0", level, 0);
    check("t2_valid0", valid, 0);

    // 3: parity error, stop error, start error with coincident clear
    send_bits({1'b1, 1'b1, 8'h1C, 1'b0}, 11);
    check("t3_par_level", level, 0);
    check("t3_par_err", frame_err, 1);
    pulse_clr();
    check("t3_par_clr", frame_err, 0);
    send_bits({1'b0, 1'b0, 8'h1C, 1'b0}, 11);
    check("t3_stop_level", level, 0);
    check("t3_stop_err", frame_err, 1);
    pulse_clr();
    check("t3_stop_clr", frame_err, 0);
    ps2_data = 1'b1;
    tick(4);
    ps2_clk = 1'b0;
    tick(2);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("t3_start_set_wins", frame_err, 1);
    tick(5);
    ps2_clk = 1'b1;
    tick(4);
    check("t3_start_bitcnt", bitcnt, 0);
    check("t3_start_level", level, 0);
    pulse_clr();

    // 4: overflow, then full push with simultaneous pop
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) exp_q.push_back(8'(i));
      send_byte(8'(i), par_tab[i-1]);
    end
    check("t4_level_full", level, 8);
    check("t4_overflow", overflow, 1);
    check("t4_head", data, 8'h01);
    drain();
    pulse_clr();
    check("t4_ovf_clr", overflow, 0);
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back(8'(i));
      send_byte(8'(i), par_tab[i-1]);
    end
    exp_q.push_back(8'h09);
    send_bits({1'b1, par_tab[8], 8'h09, 1'b0}, 10);
    ps2_data = 1'b1;
    tick(4);
    ps2_clk = 1'b0;
    tick(2);
    check("t4_full_before_pop", level, 8);
    rd_ready = 1'b1;
    tick(1);
    rd_ready = 1'b0;
    check("t4_level_pushpop", level, 8);
    check("t4_no_overflow", overflow, 0);
    tick(5);
    ps2_clk = 1'b1;
    tick(4);
    drain();

    // 5: inter-bit timeout
    fork
      send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 5);
      begin : t5_watch
        int n;
        n = 0;
        while (bitcnt != 4'd5 && n < 2000) begin @(negedge clk); n++; end
        check("t5_reach5", bitcnt, 5);
        n = 0;
        while (bitcnt != 4'd0 && n < 1000) begin @(negedge clk); n++; end
        check("t5_timeout_cycles", n, TO);
      end
    join
    tick(5);
    check("t5_frame_err", frame_err, 1);
    check("t5_bitcnt", bitcnt, 0);
    pulse_clr();
    exp_q.push_back(8'h1C);
    send_byte(8'h1C, 1'b0);
    check("t5_after_valid", valid, 1);
    check("t5_after_err", frame_err, 0);
    drain();

    // 6: reset mid-frame with a partly filled FIFO
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    check("t6_level3", level, 3);
    send_bits({1'b1, 1'b1, 8'h44, 1'b0}, 6);
    check("t6_bitcnt6", bitcnt, 6);
    resetn = 1'b0;
    #1;
    check("t6_rst_valid", valid, 0);
    check("t6_rst_level", level, 0);
    check("t6_rst_bitcnt", bitcnt, 0);
    check("t6_rst_data", data, 8'h00);
    check("t6_rst_err", frame_err, 0);
    check("t6_rst_ovf", overflow, 0);
    tick(3);
    resetn = 1'b1;
    tick(2);
    exp_q.push_back(8'h1C);
    send_byte(8'h1C, 1'b0);
    check("t6_valid", valid, 1);
    check("t6_data", data, 8'h1C);
    check("t6_level", level, 1);
    drain();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
